mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage initiator that drives the pipeline CPU's data-memory word port: MemRead/MemWrite strobes, word address, write data, combinational read data.
- Memory is big-endian, byte-addressed, 32-bit word port; byte at offset 0 is bits 31:24.
- Converts CPU load/store requests (byte/half/word, signed/unsigned) into word accesses.
- Sub-word stores use read-modify-write. Stalls the pipeline until each access completes.

Parameters:
- MEM_BYTES, 256, data memory size in bytes (power of 2); address bits above log2(MEM_BYTES) handled per Optional Feature.

Ports:
- i_clk  in  1  clock; memory writes occur on posedge
- i_rst  in  1  synchronous reset, active-high
- i_req  in  1  access request, held until o_done
- i_we  in  1  1=store, 0=load
- i_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- i_unsigned  in  1  zero-extend loads (lbu/lhu)
- i_addr  in  32  byte address
- i_wdata  in  32  store data; byte/half taken from LSBs
- o_stall  out  1  hold pipeline
- o_done  out  1  one-cycle completion pulse
- o_rvalid  out  1  one-cycle pulse with o_rdata on a completed load
- o_rdata  out  32  extended load result, registered
- o_misalign  out  1  misaligned request rejected
- o_MemRead  out  1  memory read strobe
- o_MemWrite  out  1  memory write strobe
- o_mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- o_mem_wdata  out  32  write word
- i_mem_rdata  in  32  combinational read word from memory

Behaviour:
- Reset values: state IDLE; all 1-bit outputs 0; o_rdata 0; o_mem_addr 0; o_mem_wdata 0; merge buffer 0.
- o_MemRead and o_MemWrite are gated by !i_rst, so no memory access occurs in any reset cycle.
- Strobes are never both 1. Both are 0 in IDLE and DONE.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - In IDLE, i_req with a misaligned address gives o_misalign=1 combinationally.
  - No stall, no strobe, state stays IDLE.
- FSM states: IDLE, LOAD, WR, RMW_RD, RMW_WR, DONE.
- IDLE: on a legal i_req, o_stall=1 combinationally. Next state:
  - LOAD if !i_we
  - WR if word store
  - RMW_RD if byte/half store
- LOAD: o_MemRead=1. At posedge, o_rdata <= the selected byte/half/word of i_mem_rdata, sign- or zero-extended. Next state DONE.
  - Byte select by addr[1:0]: 0->31:24, 1->23:16, 2->15:8, 3->7:0.
  - Half select by addr[1]: 0->31:16, 1->15:0.
- WR: o_MemWrite=1, o_mem_wdata=i_wdata. Next state DONE.
- RMW_RD: o_MemRead=1. Buffer <= i_mem_rdata with the addressed byte/half replaced by i_wdata[7:0] or [15:0]. Next state RMW_WR.
- RMW_WR: o_MemWrite=1, o_mem_wdata=buffer. Next state DONE.
- DONE: o_stall=0, o_done=1, o_rvalid=1 if the access was a load. i_req is ignored. Next state IDLE.
- o_stall=1 in LOAD, WR, RMW_RD and RMW_WR.
- Stall cycles per access: load 2, word store 2, sub-word store 3. DONE is the release cycle.
- i_addr, i_we, i_size and i_wdata must be stable while o_stall=1; the unit does not re-latch them.
- Reset mid-operation:
  - Any state goes to IDLE at the reset edge.
  - A pending RMW_WR or WR does not write.
  - No o_done is issued.

Optional Feature:
- Macro MAU_BUS_ERR_EN.
- Defined:
  - Adds output o_bus_err (1 bit).
  - An aligned request with i_addr >= MEM_BYTES pulses o_bus_err in IDLE.
  - No stall, no strobe; o_misalign takes priority.
- Undefined:
  - No o_bus_err port.
  - Address is reduced modulo MEM_BYTES before use, so out-of-range addresses wrap.
  - Example: 0x110 accesses 0x10 when MEM_BYTES=256.

Test Plan:
- Preload 0x10=0x8899AABB. lb 0x11 -> o_rdata 0xFFFFFF99; lbu 0x11 -> 0x00000099. o_stall high 2 cycles, then o_rvalid/o_done in the 3rd cycle.
- lh 0x12 -> 0xFFFFAABB; lhu 0x10 -> 0x00008899.
- sb 0x13, wdata 0x123456CC -> word 0x8899AACC. Exactly one o_MemRead cycle then one o_MemWrite cycle; 3 stall cycles.
- sw 0x10, 0x11223344, then lw 0x10 -> 0x11223344. sh 0x12, 0x0000BEEF, then lw -> 0x1122BEEF.
- lh 0x11 or sw 0x12 -> o_misalign=1 for 1 cycle, o_stall=0, no strobes, memory unchanged.
- sb 0x10 with i_rst asserted during RMW_WR -> no o_MemWrite, word unchanged, o_stall=0 and state IDLE next cycle. With MAU_BUS_ERR_EN, lw 0x100 -> o_bus_err pulse, no access.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: big-endian byte/half/word accesses over a 32-bit word port, RMW for sub-word stores.
// Optional macro MAU_BUS_ERR_EN adds o_bus_err for out-of-range addresses; without it addresses wrap modulo MEM_BYTES.
module mem_access_unit #(
    parameter int MEM_BYTES = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_misalign,
    output logic        o_MemRead,
    output logic        o_MemWrite,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
`ifdef MAU_BUS_ERR_EN
    output logic        o_bus_err,
`endif
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [2:0] {IDLE, LOAD, WR, RMW_RD, RMW_WR, DONE} state_t;

    state_t      state, state_next;
    logic        load_q;
    logic [31:0] merge_q;
    logic [31:0] addr_eff;
    logic        out_of_range;
    logic        is_byte, is_half, misaligned;
    logic        stall, done, rvalid, misalign, bus_err, mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata;

    // Pick the addressed byte/half (byte 0 is the MSB lane) and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                                 input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (size)
            2'b00:   load_extract = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   load_extract = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_extract = w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] off,
                                                input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        r = w;
        if (size == 2'b00) begin
            case (off)
                2'd0:    r[31:24] = wd[7:0];
                2'd1:    r[23:16] = wd[7:0];
                2'd2:    r[15:8]  = wd[7:0];
                default: r[7:0]   = wd[7:0];
            endcase
        end else if (size == 2'b01) begin
            if (off[1]) r[15:0]  = wd[15:0];
            else        r[31:16] = wd[15:0];
        end else begin
            r = wd;
        end
        store_merge = r;
    endfunction

`ifdef MAU_BUS_ERR_EN
    assign addr_eff     = i_addr;
    assign out_of_range = (i_addr >= 32'(MEM_BYTES));
`else
    assign addr_eff     = i_addr & 32'(MEM_BYTES - 1);
    assign out_of_range = 1'b0;
`endif

    assign is_byte    = (i_size == 2'b00);
    assign is_half    = (i_size == 2'b01);
    assign misaligned = (is_half && i_addr[0]) || (!is_byte && !is_half && (i_addr[1:0] != 2'b00));

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        done       = 1'b0;
        rvalid     = 1'b0;
        misalign   = 1'b0;
        bus_err    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        case (state)
            IDLE: begin
                if (i_req) begin
                    if (misaligned) begin
                        misalign = 1'b1;
                    end else if (out_of_range) begin
                        bus_err = 1'b1;
                    end else begin
                        stall = 1'b1;
                        if (!i_we)                  state_next = LOAD;
                        else if (is_byte || is_half) state_next = RMW_RD;
                        else                        state_next = WR;
                    end
                end
            end
            LOAD: begin
                stall      = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = {addr_eff[31:2], 2'b00};
                state_next = DONE;
            end
            WR: begin
                stall      = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {addr_eff[31:2], 2'b00};
                mem_wdata  = i_wdata;
                state_next = DONE;
            end
            RMW_RD: begin
                stall      = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = {addr_eff[31:2], 2'b00};
                state_next = RMW_WR;
            end
            RMW_WR: begin
                stall      = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {addr_eff[31:2], 2'b00};
                mem_wdata  = merge_q;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                rvalid     = load_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Every output is forced low during reset so a reset cycle never touches memory.
    assign o_stall     = stall     & ~i_rst;
    assign o_done      = done      & ~i_rst;
    assign o_rvalid    = rvalid    & ~i_rst;
    assign o_misalign  = misalign  & ~i_rst;
    assign o_MemRead   = mem_read  & ~i_rst;
    assign o_MemWrite  = mem_write & ~i_rst;
    assign o_mem_addr  = i_rst ? 32'd0 : mem_addr;
    assign o_mem_wdata = i_rst ? 32'd0 : mem_wdata;
`ifdef MAU_BUS_ERR_EN
    assign o_bus_err   = bus_err & ~i_rst;
`else
    logic unused_bus_err;
    assign unused_bus_err = bus_err;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            load_q  <= 1'b0;
            o_rdata <= 32'd0;
            merge_q <= 32'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && i_req)
                load_q <= ~i_we;
            if (state == LOAD)
                o_rdata <= load_extract(i_mem_rdata, addr_eff[1:0], i_size, i_unsigned);
            if (state == RMW_RD)
                merge_q <= store_merge(i_mem_rdata, addr_eff[1:0], i_size, i_wdata);
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 64-word big-endian memory model; honours MAU_BUS_ERR_EN.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst, req, we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        o_stall, o_done, o_rvalid, o_misalign, o_MemRead, o_MemWrite;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata, mem_rdata;
`ifdef MAU_BUS_ERR_EN
    logic        o_bus_err;
`endif

    logic [31:0] mem [0:63];
    logic        load_init;
    int          errors = 0;
    int          checks = 0;
    int          stall_n, rd_n, wr_n;
    logic        got_rvalid, got_both;
    logic [31:0] got_rdata;
    logic [31:0] exp_w4;

    mem_access_unit #(.MEM_BYTES(256)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_size(size),
        .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata),
        .o_stall(o_stall), .o_done(o_done), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
        .o_misalign(o_misalign), .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
`ifdef MAU_BUS_ERR_EN
        .o_bus_err(o_bus_err),
`endif
        .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[o_mem_addr[7:2]];

    always @(posedge clk) begin
        if (load_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
            mem[4] <= 32'h8899AABB;
        end else if (o_MemWrite) begin
            mem[o_mem_addr[7:2]] <= o_mem_wdata;
        end
    end

    task automatic run_access(input logic w, input logic [1:0] s, input logic u,
                              input logic [31:0] a, input logic [31:0] d);
        logic fin;
        fin = 1'b0; stall_n = 0; rd_n = 0; wr_n = 0;
        got_rvalid = 1'b0; got_both = 1'b0; got_rdata = 32'hDEADDEAD;
        @(posedge clk); #1;
        req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
        for (int i = 0; i < 8 && !fin; i++) begin
            @(negedge clk);
            if (o_stall) stall_n++;
            if (o_MemRead) rd_n++;
            if (o_MemWrite) wr_n++;
            if (o_MemRead && o_MemWrite) got_both = 1'b1;
            if (o_done) begin
                fin = 1'b1;
                got_rvalid = o_rvalid;
                got_rdata = o_rdata;
            end
        end
        req = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL access_timeout addr=%h: no o_done within 8 cycles", a);
        end
        checks++;
        if (got_both !== 1'b0) begin
            errors++;
            $display("FAIL strobes_exclusive addr=%h: MemRead and MemWrite both high", a);
        end
    endtask

    task automatic check_load(input logic [1:0] s, input logic u, input logic [31:0] a,
                              input logic [31:0] expv, input string name);
        run_access(1'b0, s, u, a, 32'd0);
        checks++;
        if (got_rdata !== expv) begin
            errors++;
            $display("FAIL %s rdata: got %h expected %h", name, got_rdata, expv);
        end
        checks++;
        if (stall_n !== 2 || rd_n !== 1 || wr_n !== 0 || got_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s timing: stall=%0d rd=%0d wr=%0d rvalid=%b expected 2 1 0 1",
                     name, stall_n, rd_n, wr_n, got_rvalid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0;
        addr = 32'h10; wdata = 32'h0;
        repeat (2) @(posedge clk);
        load_init = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_stall, o_done, o_rvalid, o_misalign, o_MemRead, o_MemWrite} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {o_stall, o_done, o_rvalid, o_misalign, o_MemRead, o_MemWrite});
        end
        checks++;
        if (o_rdata !== 32'd0 || o_mem_addr !== 32'd0 || o_mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h expected zeros",
                     o_rdata, o_mem_addr, o_mem_wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
    endtask

    task automatic test_load;
        check_load(2'b00, 1'b0, 32'h11, 32'hFFFFFF99, "lb_11");
        check_load(2'b00, 1'b1, 32'h11, 32'h00000099, "lbu_11");
        check_load(2'b01, 1'b0, 32'h12, 32'hFFFFAABB, "lh_12");
        check_load(2'b01, 1'b1, 32'h10, 32'h00008899, "lhu_10");
        check_load(2'b00, 1'b0, 32'h10, 32'hFFFFFF88, "lb_10");
        check_load(2'b00, 1'b0, 32'h13, 32'hFFFFFFBB, "lb_13");
    endtask

    task automatic test_sub_store;
        run_access(1'b1, 2'b00, 1'b0, 32'h13, 32'h123456CC);
        checks++;
        if (stall_n !== 3 || rd_n !== 1 || wr_n !== 1 || got_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL sb_13 timing: stall=%0d rd=%0d wr=%0d rvalid=%b expected 3 1 1 0",
                     stall_n, rd_n, wr_n, got_rvalid);
        end
        checks++;
        if (mem[4] !== 32'h8899AACC) begin
            errors++;
            $display("FAIL sb_13 mem: got %h expected 8899aacc", mem[4]);
        end
    endtask

    task automatic test_word_store;
        run_access(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
        checks++;
        if (stall_n !== 2 || rd_n !== 0 || wr_n !== 1 || mem[4] !== 32'h11223344) begin
            errors++;
            $display("FAIL sw_10: stall=%0d rd=%0d wr=%0d mem=%h expected 2 0 1 11223344",
                     stall_n, rd_n, wr_n, mem[4]);
        end
        check_load(2'b10, 1'b0, 32'h10, 32'h11223344, "lw_after_sw");
        run_access(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF);
        checks++;
        if (stall_n !== 3 || mem[4] !== 32'h1122BEEF) begin
            errors++;
            $display("FAIL sh_12: stall=%0d mem=%h expected 3 1122beef", stall_n, mem[4]);
        end
        check_load(2'b11, 1'b0, 32'h10, 32'h1122BEEF, "lw_size11_after_sh");
        exp_w4 = 32'h1122BEEF;
    endtask

    task automatic check_reject(input logic w, input logic [1:0] s, input logic [31:0] a,
                                input logic exp_mis, input logic exp_be, input string name);
        logic be;
        @(posedge clk); #1;
        req = 1'b1; we = w; size = s; uns = 1'b0; addr = a; wdata = 32'hA5A5A5A5;
        @(negedge clk);
`ifdef MAU_BUS_ERR_EN
        be = o_bus_err;
`else
        be = 1'b0;
`endif
        checks++;
        if (o_misalign !== exp_mis || be !== exp_be || o_stall !== 1'b0 ||
            o_MemRead !== 1'b0 || o_MemWrite !== 1'b0) begin
            errors++;
            $display("FAIL %s: misalign=%b buserr=%b stall=%b rd=%b wr=%b expected %b %b 0 0 0",
                     name, o_misalign, be, o_stall, o_MemRead, o_MemWrite, exp_mis, exp_be);
        end
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        checks++;
        if (o_misalign !== 1'b0 || o_stall !== 1'b0 || mem[4] !== exp_w4) begin
            errors++;
            $display("FAIL %s after: misalign=%b stall=%b mem=%h expected 0 0 %h",
                     name, o_misalign, o_stall, mem[4], exp_w4);
        end
    endtask

    task automatic test_misalign;
        check_reject(1'b0, 2'b01, 32'h11, 1'b1, 1'b0, "misalign_lh_11");
        check_reject(1'b1, 2'b10, 32'h12, 1'b1, 1'b0, "misalign_sw_12");
    endtask

    task automatic test_addr_range;
`ifdef MAU_BUS_ERR_EN
        check_reject(1'b0, 2'b10, 32'h100, 1'b0, 1'b1, "bus_err_lw_100");
        check_reject(1'b0, 2'b01, 32'h101, 1'b1, 1'b0, "misalign_over_bus_err");
`else
        check_load(2'b10, 1'b0, 32'h110, 32'h1122BEEF, "wrap_lw_110");
        run_access(1'b1, 2'b00, 1'b0, 32'h213, 32'h00000077);
        exp_w4 = 32'h1122BE77;
        checks++;
        if (mem[4] !== exp_w4) begin
            errors++;
            $display("FAIL wrap_sb_213: got %h expected %h", mem[4], exp_w4);
        end
`endif
    endtask

    task automatic test_reset_mid_rmw;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h10; wdata = 32'h00000055;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (o_MemRead !== 1'b1 || o_stall !== 1'b1) begin
            errors++;
            $display("FAIL rmw_rd_phase: rd=%b stall=%b expected 1 1", o_MemRead, o_stall);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (o_MemWrite !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_rmw_wr: wr=%b done=%b expected 0 0", o_MemWrite, o_done);
        end
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        @(negedge clk);
        checks++;
        if (o_stall !== 1'b0 || o_done !== 1'b0 || o_MemRead !== 1'b0 || o_MemWrite !== 1'b0 ||
            mem[4] !== exp_w4) begin
            errors++;
            $display("FAIL after_rst_rmw: stall=%b done=%b rd=%b wr=%b mem=%h expected 0 0 0 0 %h",
                     o_stall, o_done, o_MemRead, o_MemWrite, mem[4], exp_w4);
        end
        check_load(2'b10, 1'b0, 32'h10, exp_w4, "lw_after_rst");
    endtask

    task automatic test_back_to_back;
        run_access(1'b1, 2'b10, 1'b0, 32'h20, 32'hAABBCCDD);
        checks++;
        if (mem[8] !== 32'hAABBCCDD) begin
            errors++;
            $display("FAIL b2b_sw_20: got %h expected aabbccdd", mem[8]);
        end
        check_load(2'b00, 1'b1, 32'h21, 32'h000000BB, "b2b_lbu_21");
        check_load(2'b01, 1'b0, 32'h22, 32'hFFFFCCDD, "b2b_lh_22");
    endtask

    initial begin
        load_init = 1'b1;
        exp_w4 = 32'h8899AABB;
        test_reset;
        test_load;
        test_sub_store;
        test_word_store;
        test_misalign;
        test_addr_range;
        test_reset_mid_rmw;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
